gps_zda_emitter: RTL

//  Transmit-side counterpart of the GPZDA receive path. Latches a date/time and serialises it as one

---
 rtl/gps_pkg.sv | 31 +++
 rtl/gps_hex_ascii.sv | 19 +
 rtl/gps_zda_emitter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/gps_pkg.sv
// Shared GPS NMEA definitions: character width, default sentence head, FSM encoding
// and the ASCII constants used by both the ZDA emitter and the GPZDA parser.
package gps_pkg;

    localparam int B = 8;

    localparam logic [6*B-1:0] PREFIX_DEFAULT  = "$GPZDA";
    localparam logic [2*B-1:0] CENTURY_DEFAULT = "20";

    typedef enum logic [1:0] {
        S_Idle  = 2'd0,
        S_Body  = 2'd1,
        S_Check = 2'd2,
        S_Tail  = 2'd3
    } state_t;

    // Body covers '$' through the final "00" field: indices 0..32.
    localparam logic [5:0] BODY_LAST  = 6'd32;
    localparam logic [5:0] CHECK_LAST = 6'd2;
    localparam logic [5:0] TAIL_LAST  = 6'd1;

    localparam logic [B-1:0] CHAR_DOLLAR = 8'h24;
    localparam logic [B-1:0] CHAR_COMMA  = 8'h2C;
    localparam logic [B-1:0] CHAR_DOT    = 8'h2E;
    localparam logic [B-1:0] CHAR_STAR   = 8'h2A;
    localparam logic [B-1:0] CHAR_ZERO   = 8'h30;
    localparam logic [B-1:0] CHAR_UPPER_A = 8'h41;
    localparam logic [B-1:0] CHAR_CR     = 8'h0D;
    localparam logic [B-1:0] CHAR_LF     = 8'h0A;

endpackage

// File: rtl/gps_hex_ascii.sv
// Combinational nibble to uppercase ASCII hex digit ('0'-'9', 'A'-'F').
module gps_hex_ascii
    import gps_pkg::*;
#(
    parameter int W = gps_pkg::B
) (
    input  logic [3:0]   i_nibble,
    output logic [W-1:0] o_ascii
);

    always_comb begin
        if (i_nibble < 4'd10) begin
            o_ascii = W'(CHAR_ZERO) + W'(i_nibble);
        end else begin
            o_ascii = W'(CHAR_UPPER_A) + W'(i_nibble) - W'(10);
        end
    end

endmodule

// File: rtl/gps_zda_emitter.sv
// Serialises a latched date/time as one NMEA "$GPZDA,...*CS\r\n" sentence over valid/ready.
// GPS_ZDA_CHECKSUM_EN builds the '*' + two-hex-digit checksum section; without it the body ends in CR LF.
module gps_zda_emitter
    import gps_pkg::*;
#(
    parameter int              B       = gps_pkg::B,
    parameter logic [6*B-1:0]  PREFIX  = PREFIX_DEFAULT,
    parameter logic [2*B-1:0]  CENTURY = CENTURY_DEFAULT
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [2*B-1:0] hour,
    input  logic [2*B-1:0] minute,
    input  logic [2*B-1:0] second,
    input  logic [2*B-1:0] day,
    input  logic [2*B-1:0] month,
    input  logic [2*B-1:0] year,
    output logic           busy,
    output logic           done,
    output logic [B-1:0]   tx_data,
    output logic           tx_valid,
    input  logic           tx_ready
);

    state_t         r_state;
    logic [5:0]     r_index;
    logic [B-1:0]   r_tx_data;
    logic           r_tx_valid;
    logic           r_done;
    logic [2*B-1:0] r_hour, r_minute, r_second, r_day, r_month, r_year;

    logic           w_xfer;
    logic           w_start_ok;
    logic [5:0]     w_index_inc;

    assign w_xfer      = r_tx_valid && tx_ready;
    assign w_start_ok  = (r_state == S_Idle) && start;
    assign w_index_inc = r_index + 6'd1;

`ifdef GPS_ZDA_CHECKSUM_EN
    localparam state_t AFTER_BODY = S_Check;

    logic [B-1:0] r_csum;
    logic [B-1:0] w_hex_hi;
    logic [B-1:0] w_hex_lo;

    gps_hex_ascii #(.W(B)) u_hex_hi (.i_nibble(r_csum[7:4]), .o_ascii(w_hex_hi));
    gps_hex_ascii #(.W(B)) u_hex_lo (.i_nibble(r_csum[3:0]), .o_ascii(w_hex_lo));

    // '$' (index 0) is excluded; r_csum is final before the '*' is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_csum <= '0;
        end else if (w_start_ok) begin
            r_csum <= '0;
        end else if (w_xfer && (r_state == S_Body) && (r_index != 6'd0)) begin
            r_csum <= r_csum ^ r_tx_data;
        end
    end
`else
    localparam state_t AFTER_BODY = S_Tail;
`endif

    // Character presented at (st, idx); next-position lookup keeps tx_data registered.
    function automatic logic [B-1:0] sel_byte(input state_t st, input logic [5:0] idx);
        logic [B-1:0] c;
        c = '0;
        case (st)
            S_Body: begin
                case (idx)
                    6'd0:  c = PREFIX[6*B-1 -: B];
                    6'd1:  c = PREFIX[5*B-1 -: B];
                    6'd2:  c = PREFIX[4*B-1 -: B];
                    6'd3:  c = PREFIX[3*B-1 -: B];
                    6'd4:  c = PREFIX[2*B-1 -: B];
                    6'd5:  c = PREFIX[B-1:0];
                    6'd6, 6'd16, 6'd19, 6'd22, 6'd27, 6'd30: c = CHAR_COMMA;
                    6'd7:  c = r_hour[2*B-1 -: B];
                    6'd8:  c = r_hour[B-1:0];
                    6'd9:  c = r_minute[2*B-1 -: B];
                    6'd10: c = r_minute[B-1:0];
                    6'd11: c = r_second[2*B-1 -: B];
                    6'd12: c = r_second[B-1:0];
                    6'd13: c = CHAR_DOT;
                    6'd14, 6'd15, 6'd28, 6'd29, 6'd31, 6'd32: c = CHAR_ZERO;
                    6'd17: c = r_day[2*B-1 -: B];
                    6'd18: c = r_day[B-1:0];
                    6'd20: c = r_month[2*B-1 -: B];
                    6'd21: c = r_month[B-1:0];
                    6'd23: c = CENTURY[2*B-1 -: B];
                    6'd24: c = CENTURY[B-1:0];
                    6'd25: c = r_year[2*B-1 -: B];
                    6'd26: c = r_year[B-1:0];
                    default: c = '0;
                endcase
            end
`ifdef GPS_ZDA_CHECKSUM_EN
            S_Check: begin
                case (idx)
                    6'd0:    c = CHAR_STAR;
                    6'd1:    c = w_hex_hi;
                    default: c = w_hex_lo;
                endcase
            end
`endif
            S_Tail:  c = (idx == 6'd0) ? CHAR_CR : CHAR_LF;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_Idle;
            r_index    <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_done     <= 1'b0;
            r_hour     <= '0;
            r_minute   <= '0;
            r_second   <= '0;
            r_day      <= '0;
            r_month    <= '0;
            r_year     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_Idle: begin
                    if (start) begin
                        r_hour     <= hour;
                        r_minute   <= minute;
                        r_second   <= second;
                        r_day      <= day;
                        r_month    <= month;
                        r_year     <= year;
                        r_state    <= S_Body;
                        r_index    <= '0;
                        r_tx_data  <= sel_byte(S_Body, 6'd0);
                        r_tx_valid <= 1'b1;
                    end
                end
                S_Body: begin
                    if (w_xfer) begin
                        if (r_index == BODY_LAST) begin
                            r_state   <= AFTER_BODY;
                            r_index   <= '0;
                            r_tx_data <= sel_byte(AFTER_BODY, 6'd0);
                        end else begin
                            r_index   <= w_index_inc;
                            r_tx_data <= sel_byte(S_Body, w_index_inc);
                        end
                    end
                end
`ifdef GPS_ZDA_CHECKSUM_EN
                S_Check: begin
                    if (w_xfer) begin
                        if (r_index == CHECK_LAST) begin
                            r_state   <= S_Tail;
                            r_index   <= '0;
                            r_tx_data <= sel_byte(S_Tail, 6'd0);
                        end else begin
                            r_index   <= w_index_inc;
                            r_tx_data <= sel_byte(S_Check, w_index_inc);
                        end
                    end
                end
`endif
                S_Tail: begin
                    if (w_xfer) begin
                        if (r_index == TAIL_LAST) begin
                            r_state    <= S_Idle;
                            r_index    <= '0;
                            r_tx_data  <= '0;
                            r_tx_valid <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_index   <= w_index_inc;
                            r_tx_data <= sel_byte(S_Tail, w_index_inc);
                        end
                    end
                end
                default: begin
                    r_state    <= S_Idle;
                    r_index    <= '0;
                    r_tx_data  <= '0;
                    r_tx_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = (r_state != S_Idle);
    assign done     = r_done;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;

endmodule
